// File: rtl/collision_pkg.sv
// Shared definitions for the collision matrix.
//   MAX_OBJ / MAX_PAIRS  upper bounds on channel and pair counts
//   collision_evt_t      event record {pair, x, y} carried by the event FIFO
//   num_pairs()          number of unordered channel pairs for n channels
//   pair_index()         lexicographic index of pair (i,j), i<j
package collision_pkg;

    localparam int MAX_OBJ   = 8;
    localparam int MAX_PAIRS = MAX_OBJ * (MAX_OBJ - 1) / 2;
    localparam int PAIR_W    = 5;
    localparam int COORD_W   = 11;

    typedef struct packed {
        logic [PAIR_W-1:0]  pair;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } collision_evt_t;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Pairs starting with row i are preceded by (n-1) + (n-2) + ... + (n-i)
    // entries, which is i*(2n-i-1)/2.
    function automatic int pair_index(input int i, input int j, input int n);
        return i * (2 * n - i - 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/collision_event_fifo.sv
// Synchronous FIFO for collision events.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (empties the FIFO)
//   push, din      write request and event; ignored while full unless a pop
//                  happens in the same cycle
//   pop            read request; ignored while empty
//   dout           head event, forced to zero while empty
//   full, empty    occupancy flags (registered count, so a pushed entry is
//                  visible only from the following cycle)
module collision_event_fifo
    import collision_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  collision_evt_t din,
    input  logic           pop,
    output collision_evt_t dout,
    output logic           full,
    output logic           empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    collision_evt_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so push and pop both succeed when full.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/collision_matrix.sv
// Pairwise collision detector for VGA drawing-request channels.
// Build option: define COLLISION_EVENT_FIFO_EN to include the first-hit event
// FIFO; without it the evt_* outputs are tied to zero and evt_ready is ignored.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   startOfFrame      one-cycle frame start pulse
//   drawing_request   per-channel draw request for the current pixel
//   pixelX, pixelY    current signed pixel coordinate
//   hit_pulse         one-cycle pulse per pair on its first overlap in a frame
//   frame_hits        per-pair hit summary of the previous frame
//   out_of_bounds     registered: channel drawing below Y_LIMIT
//   evt_valid/ready   event read handshake
//   evt_pair/x/y      head event
//   evt_overflow      sticky: an event was discarded
module collision_matrix
    import collision_pkg::*;
#(
    parameter int                   NUM_OBJ    = 5,
    parameter logic [MAX_PAIRS-1:0] PAIR_MASK  = '1,
    parameter int                   Y_LIMIT    = 479,
    parameter int                   FIFO_DEPTH = 8,
    localparam int                  NUM_PAIRS  = num_pairs(NUM_OBJ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic [NUM_OBJ-1:0]       drawing_request,
    input  logic signed [10:0]       pixelX,
    input  logic signed [10:0]       pixelY,
    output logic [NUM_PAIRS-1:0]     hit_pulse,
    output logic [NUM_PAIRS-1:0]     frame_hits,
    output logic [NUM_OBJ-1:0]       out_of_bounds,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [4:0]               evt_pair,
    output logic signed [10:0]       evt_x,
    output logic signed [10:0]       evt_y,
    output logic                     evt_overflow
);

    localparam logic signed [10:0] Y_LIM = 11'(Y_LIMIT);

    logic [NUM_PAIRS-1:0] overlap;
    logic [NUM_PAIRS-1:0] hit_flag;
    logic [NUM_PAIRS-1:0] first_hit;
    logic                 y_over;

    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_col
            localparam int K = pair_index(gi, gj, NUM_OBJ);
            assign overlap[K] = drawing_request[gi] & drawing_request[gj] & PAIR_MASK[K];
        end
    end

    // At a frame start the old flags no longer gate anything: an overlap in
    // that cycle already belongs to the new frame.
    assign first_hit = overlap & (startOfFrame ? {NUM_PAIRS{1'b1}} : ~hit_flag);
    assign y_over    = (pixelY > Y_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_flag      <= '0;
            hit_pulse     <= '0;
            frame_hits    <= '0;
            out_of_bounds <= '0;
        end else begin
            hit_flag      <= (startOfFrame ? '0 : hit_flag) | overlap;
            hit_pulse     <= first_hit;
            out_of_bounds <= drawing_request & {NUM_OBJ{y_over}};
            if (startOfFrame) frame_hits <= hit_flag;
        end
    end

`ifdef COLLISION_EVENT_FIFO_EN

    collision_evt_t evt_in;
    collision_evt_t evt_head;
    logic [4:0]     evt_k;
    logic           evt_push;
    logic           multi_hit;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_drop;

    // Lowest-index first hit wins the single push slot of this cycle.
    always_comb begin
        evt_push = 1'b0;
        evt_k    = '0;
        for (int k = NUM_PAIRS - 1; k >= 0; k--) begin
            if (first_hit[k]) begin
                evt_push = 1'b1;
                evt_k    = 5'(k);
            end
        end
    end

    // x & (x-1) is nonzero exactly when more than one bit is set.
    assign multi_hit = |(first_hit & (first_hit - 1'b1));
    assign fifo_drop = evt_push & fifo_full & ~(evt_ready & ~fifo_empty);

    assign evt_in.pair = evt_k;
    assign evt_in.x    = pixelX;
    assign evt_in.y    = pixelY;

    collision_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (evt_push),
        .din   (evt_in),
        .pop   (evt_ready),
        .dout  (evt_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_overflow <= 1'b0;
        end else if (multi_hit | fifo_drop) begin
            evt_overflow <= 1'b1;
        end
    end

    assign evt_valid = ~fifo_empty;
    assign evt_pair  = evt_head.pair;
    assign evt_x     = evt_head.x;
    assign evt_y     = evt_head.y;

`else

    wire unused_evt = ^{evt_ready, pixelX};

    assign evt_valid    = 1'b0;
    assign evt_pair     = '0;
    assign evt_x        = '0;
    assign evt_y        = '0;
    assign evt_overflow = 1'b0;

`endif

endmodule
